rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//  Shares the single register-file write port between the pipeline writeback stage (priority
//  requester) and a long-latency auxiliary unit (mult/div) that posts results via valid/ready.
//  Aux results wait in a DEPTH-entry FIFO and drain in idle writeback slots. A starvation guard
//  steals one pipeline slot via pipe_stall. Sits between writeback and the register file.
// PARAMETERS
//  DEPTH     4   aux FIFO entries; power of two, >=2
//  MAX_WAIT  8   cycles the FIFO head may wait before a slot is stolen; >=2
// PORTS
//  clock5        in   1   clock
//  reset5        in   1   async reset, active-low
//  wb_en         in   1   writeback write request
//  wb_addr       in   5   writeback destination register
//  wb_data       in   32  writeback data
//  aux_valid     in   1   aux result valid
//  aux_addr      in   5   aux destination register
//  aux_data      in   32  aux result data
//  aux_ready     out  1   FIFO can accept (= !full)
//  pipe_stall    out  1   writeback request not taken this cycle; upstream holds IR/data stable
//  rf_we         out  1   register-file write enable (registered)
//  rf_addr       out  5   register-file write address (registered)
//  rf_data       out  32  register-file write data (registered)
//  pending_mask  out  32  bit i set while any FIFO entry targets register i (hazard unit input)
// BEHAVIOUR
//  - Reset (reset5 low, async): FIFO emptied, pointers/count/age 0, state NORMAL, rf_we/rf_addr/
//    rf_data 0, pipe_stall 0, aux_ready 1, pending_mask 0. Reset mid-operation discards entries.
//  - Pipeline request valid = wb_en & (wb_addr!=0). Aux push = aux_valid & aux_ready; aux_addr==0
//    handshakes but is not enqueued.
//  - aux_ready from registered count only: no push when full, even with a same-cycle pop.
//  - Write port: one write per cycle, latched at posedge clock5, visible next cycle (1-cycle
//    latency). rf_we=0 cycle -> rf_addr/rf_data hold previous value.
//  - FSM NORMAL: pipeline request valid -> write it; else FIFO non-empty -> pop head, write it;
//    else rf_we=0.
//  - Age counter: increments each cycle FIFO is non-empty and head not popped; clears on pop or
//    empty. Age==MAX_WAIT-1 and head not popped -> STEAL next cycle.
//  - FSM STEAL (1 cycle): pipe_stall=1; head popped and written regardless of wb_en; pipeline
//    request ignored, re-presented next cycle; return to NORMAL.
//  - Simultaneous push+pop on non-full FIFO: count unchanged, both pointers advance; pointers
//    wrap modulo DEPTH. Push into empty FIFO: entry poppable the following cycle, never same cycle.
//  - Order: aux entries retire in FIFO order. No ordering vs. pipeline writes; hazard unit must
//    stall an instruction whose rd or rs hits pending_mask.
//  - pending_mask: combinational OR over valid FIFO entries' decoded addresses.
// CONFIGURATION
//  - RF_ARB_STATS_EN defined: adds outputs steal_cnt[15:0] (STEAL cycles) and drain_cnt[15:0]
//    (aux writes). Both saturate at 16'hFFFF, reset to 0.
//  - Not defined: ports/counters absent; all other behaviour identical.
// STRUCTURE
//  - Package dlx_wb_pkg: REG_AW=5, DATA_W=32, REG_ZERO=5'd0, arb_state_t {NORMAL, STEAL},
//    rf_wr_t struct {addr,data}.
//  - Sub-module rf_arb_fifo: DEPTH-deep, push/pop/full/empty/count, exports entry valid+addr
//    vectors for pending_mask. Arbitration FSM, age counter, write-port register in top.
// TESTING
//  - Reset: reset5 low mid-stream with 3 entries queued -> rf_we=0, aux_ready=1,
//    pending_mask=0 asynchronously.
//  - Idle drain: wb_en=0, push {r7,0x11} -> next cycle pending_mask[7]=1; following cycle rf_we=1,
//    rf_addr=7, rf_data=0x11; mask clears.
//  - Priority: wb_en=1 {r3,0xAA} with queued {r9,0x55} -> r3 written first, r9 first idle cycle.
//  - Starvation: wb_en=1 every cycle, queue {r5,0x1} -> pipe_stall=1 exactly once, 8 cycles after
//    push; that cycle writes r5; stalled wb request written next cycle.
//  - Full/r0: push 5 entries, DEPTH=4, wb_en held -> aux_ready=0 after 4th; push to r0 handshakes,
//    never written, mask unchanged.
//  - Push+pop at full with wrap: sustain 10 alternating writes -> FIFO order preserved, no loss.

Source files
------------

// File: rtl/dlx_wb_pkg.sv
// -----------------------------------------------------------------------------
// dlx_wb_pkg
//   Shared types and constants for the writeback / register-file write path.
//   REG_AW/DATA_W size the register file, REG_ZERO is the hard-wired zero
//   register, arb_state_t encodes the write-port arbiter FSM and rf_wr_t is one
//   register-file write (destination + data).
// -----------------------------------------------------------------------------
package dlx_wb_pkg;

    localparam int REG_AW   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 1 << REG_AW;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        NORMAL = 1'b0,
        STEAL  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } rf_wr_t;

    // One-hot decode of a register number, used to build hazard masks.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
        logic [NUM_REGS-1:0] m;
        m    = '0;
        m[r] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/rf_arb_fifo.sv
// -----------------------------------------------------------------------------
// rf_arb_fifo
//   DEPTH-entry FIFO holding auxiliary-unit register writes until the write
//   port is free. Exposes per-entry valid bits and destination addresses so the
//   parent can build a pending-register mask for the hazard unit.
//
//   Ports
//     clock5, reset5        clock, asynchronous active-low reset
//     push, push_addr/data  enqueue one write (ignored when full)
//     pop                   dequeue the head (ignored when empty)
//     head_addr/head_data   current head entry
//     full, empty           derived from the registered occupancy count
//     entry_valid           one bit per storage slot, set while it holds data
//     entry_addr            destination register of every slot, packed
// -----------------------------------------------------------------------------
module rf_arb_fifo
    import dlx_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clock5,
    input  logic                    reset5,
    input  logic                    push,
    input  logic [REG_AW-1:0]       push_addr,
    input  logic [DATA_W-1:0]       push_data,
    input  logic                    pop,
    output logic [REG_AW-1:0]       head_addr,
    output logic [DATA_W-1:0]       head_data,
    output logic                    full,
    output logic                    empty,
    output logic [DEPTH-1:0]        entry_valid,
    output logic [DEPTH*REG_AW-1:0] entry_addr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    rf_wr_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers wrap naturally because DEPTH is a power of two. A slot is never
    // pushed and popped together: that needs wr_ptr == rd_ptr, i.e. empty or full.
    // NOTE: all state in clocked blocks uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock5 or negedge reset5) begin
        if (!reset5) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (do_push) begin
                wr_ptr              <= wr_ptr + 1'b1;
                entry_valid[wr_ptr] <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr              <= rd_ptr + 1'b1;
                entry_valid[rd_ptr] <= 1'b0;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: payload storage has no reset; entry_valid and count decide what is
    // live, so stale contents are never observed after reset.
    always_ff @(posedge clock5) begin
        if (do_push) begin
            mem[wr_ptr] <= '{addr: push_addr, data: push_data};
        end
    end

    assign head_addr = mem[rd_ptr].addr;
    assign head_data = mem[rd_ptr].data;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry_addr
        assign entry_addr[i*REG_AW +: REG_AW] = mem[i].addr;
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
//   Shares the single register-file write port between the writeback stage
//   (priority requester) and a long-latency auxiliary unit. Aux results queue
//   in rf_arb_fifo and drain in idle writeback slots; if the queue head waits
//   MAX_WAIT cycles a pipeline slot is stolen for one cycle via pipe_stall.
//
//   Optional build macro: RF_ARB_STATS_EN adds steal_cnt/drain_cnt outputs.
//
//   Ports
//     clock5, reset5              clock, asynchronous active-low reset
//     wb_en/wb_addr/wb_data       writeback write request (r0 is no request)
//     aux_valid/aux_addr/aux_data aux result handshake (r0 accepted, dropped)
//     aux_ready                   queue can accept (from registered count)
//     pipe_stall                  writeback request not taken this cycle
//     rf_we/rf_addr/rf_data       registered register-file write port
//     pending_mask                registers targeted by queued aux writes
//     steal_cnt, drain_cnt        (stats build) steal cycles / aux writes
// -----------------------------------------------------------------------------
module rf_write_arbiter
    import dlx_wb_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic        clock5,
    input  logic        reset5,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        aux_valid,
    input  logic [4:0]  aux_addr,
    input  logic [31:0] aux_data,
    output logic        aux_ready,
    output logic        pipe_stall,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data,
    output logic [31:0] pending_mask
`ifdef RF_ARB_STATS_EN
    ,
    output logic [15:0] steal_cnt,
    output logic [15:0] drain_cnt
`endif
);

    localparam int AGE_W = $clog2(MAX_WAIT);

    arb_state_t             state;
    arb_state_t             state_next;
    logic [AGE_W-1:0]       age;
    logic                   pipe_req;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [REG_AW-1:0]      head_addr;
    logic [DATA_W-1:0]      head_data;
    logic [DEPTH-1:0]       entry_valid;
    logic [DEPTH*REG_AW-1:0] entry_addr;
    logic                   wr_en;
    rf_wr_t                 wr_next;

    assign pipe_req  = wb_en & (wb_addr != REG_ZERO);
    assign aux_ready = ~fifo_full;
    // Writes to r0 complete the handshake but are architecturally void.
    assign fifo_push = aux_valid & aux_ready & (aux_addr != REG_ZERO);

    rf_arb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock5      (clock5),
        .reset5      (reset5),
        .push        (fifo_push),
        .push_addr   (aux_addr),
        .push_data   (aux_data),
        .pop         (fifo_pop),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    always_ff @(posedge clock5 or negedge reset5) begin
        if (!reset5) begin
            state <= NORMAL;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = NORMAL;
        pipe_stall = 1'b0;
        fifo_pop   = 1'b0;
        wr_en      = 1'b0;
        wr_next    = '0;
        case (state)
            NORMAL: begin
                if (pipe_req) begin
                    wr_en   = 1'b1;
                    wr_next = '{addr: wb_addr, data: wb_data};
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    wr_en    = 1'b1;
                    wr_next  = '{addr: head_addr, data: head_data};
                end
                // Head has waited its full budget and still lost: take the next slot.
                if (!fifo_empty && !fifo_pop && age == AGE_W'(MAX_WAIT - 1)) begin
                    state_next = STEAL;
                end
            end
            STEAL: begin
                // The writeback request is refused and re-presented next cycle.
                pipe_stall = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    wr_en    = 1'b1;
                    wr_next  = '{addr: head_addr, data: head_data};
                end
            end
            default: state_next = NORMAL;
        endcase
    end

    // Cycles the current head has waited without retiring.
    always_ff @(posedge clock5 or negedge reset5) begin
        if (!reset5) begin
            age <= '0;
        end else if (fifo_empty || fifo_pop) begin
            age <= '0;
        end else begin
            age <= age + 1'b1;
        end
    end

    // Address/data hold their last written value on idle cycles.
    always_ff @(posedge clock5 or negedge reset5) begin
        if (!reset5) begin
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
        end else begin
            rf_we <= wr_en;
            if (wr_en) begin
                rf_addr <= wr_next.addr;
                rf_data <= wr_next.data;
            end
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                pending_mask = pending_mask | reg_onehot(entry_addr[i*REG_AW +: REG_AW]);
            end
        end
    end

`ifdef RF_ARB_STATS_EN
    always_ff @(posedge clock5 or negedge reset5) begin
        if (!reset5) begin
            steal_cnt <= '0;
            drain_cnt <= '0;
        end else begin
            if (state == STEAL && steal_cnt != 16'hFFFF) begin
                steal_cnt <= steal_cnt + 16'd1;
            end
            if (fifo_pop && drain_cnt != 16'hFFFF) begin
                drain_cnt <= drain_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_write_arbiter
//   Self-checking bench for rf_write_arbiter (DEPTH=4, MAX_WAIT=8). A queue
//   based reference model predicts every output each cycle; directed scenarios
//   add literal expectations, then a randomized phase runs against the model.
// -----------------------------------------------------------------------------
module tb_rf_write_arbiter;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic        clock5 = 1'b0;
    logic        reset5 = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        aux_valid = 1'b0;
    logic [4:0]  aux_addr = '0;
    logic [31:0] aux_data = '0;
    logic        aux_ready;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [31:0] pending_mask;
`ifdef RF_ARB_STATS_EN
    logic [15:0] steal_cnt;
    logic [15:0] drain_cnt;
`endif

    rf_write_arbiter #(
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clock5       (clock5),
        .reset5       (reset5),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .aux_valid    (aux_valid),
        .aux_addr     (aux_addr),
        .aux_data     (aux_data),
        .aux_ready    (aux_ready),
        .pipe_stall   (pipe_stall),
        .rf_we        (rf_we),
        .rf_addr      (rf_addr),
        .rf_data      (rf_data),
        .pending_mask (pending_mask)
`ifdef RF_ARB_STATS_EN
        ,
        .steal_cnt    (steal_cnt),
        .drain_cnt    (drain_cnt)
`endif
    );

    always #5 clock5 = ~clock5;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         mq[$];
    int          m_wait = 0;       // cycles the head has waited unretired
    bit          m_steal = 0;      // current cycle is a stolen slot
    bit          m_we = 0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    int          m_steals = 0;
    int          m_drains = 0;

    task automatic model_reset();
        mq.delete();
        m_wait   = 0;
        m_steal  = 0;
        m_we     = 0;
        m_addr   = '0;
        m_data   = '0;
        m_steals = 0;
        m_drains = 0;
    endtask

    task automatic model_step();
        int  pre_size;
        bit  popped;
        bit  steal_next;
        wr_t e;
        pre_size   = mq.size();
        popped     = 0;
        steal_next = 0;
        if (m_steal && pre_size > 0) begin
            e = mq.pop_front();
            m_we = 1; m_addr = e.addr; m_data = e.data;
            popped = 1;
            m_drains++;
        end else if (!m_steal && wb_en && wb_addr != 0) begin
            m_we = 1; m_addr = wb_addr; m_data = wb_data;
        end else if (!m_steal && pre_size > 0) begin
            e = mq.pop_front();
            m_we = 1; m_addr = e.addr; m_data = e.data;
            popped = 1;
            m_drains++;
        end else begin
            m_we = 0;
        end
        if (m_steal) m_steals++;
        if (pre_size > 0 && !popped) begin
            if (m_wait == MAX_WAIT - 1) steal_next = 1;
            m_wait++;
        end else begin
            m_wait = 0;
        end
        m_steal = steal_next;
        // Acceptance depends on occupancy before this edge's pop.
        if (aux_valid && pre_size < DEPTH && aux_addr != 0) begin
            mq.push_back('{addr: aux_addr, data: aux_data});
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        foreach (mq[i]) m[mq[i].addr] = 1'b1;
        return m;
    endfunction

    always @(posedge clock5 or negedge reset5) begin
        if (!reset5) model_reset();
        else         model_step();
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_en = 0;

    always @(negedge clock5) begin
        if (cmp_en) begin
            check("cyc_rf_we",        rf_we,        m_we);
            check("cyc_rf_addr",      rf_addr,      m_addr);
            check("cyc_rf_data",      rf_data,      m_data);
            check("cyc_pipe_stall",   pipe_stall,   m_steal);
            check("cyc_aux_ready",    aux_ready,    mq.size() < DEPTH);
            check("cyc_pending_mask", pending_mask, model_mask());
`ifdef RF_ARB_STATS_EN
            check("cyc_steal_cnt",    steal_cnt,    m_steals);
            check("cyc_drain_cnt",    drain_cnt,    m_drains);
`endif
        end
    end

    // ---------------- stimulus ----------------
    wr_t obs[$];
    wr_t exp_list[$];
    bit  rec_en = 0;

    // Apply one cycle of inputs, then return 1 time unit after the edge.
    task automatic cyc(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input bit av, input logic [4:0] aa, input logic [31:0] ad);
        wb_en = we; wb_addr = wa; wb_data = wd;
        aux_valid = av; aux_addr = aa; aux_data = ad;
        @(posedge clock5);
        #1;
        if (rec_en && rf_we) obs.push_back('{addr: rf_addr, data: rf_data});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int          idx;
        int          stall_seen;
        int          stall_at;
        logic [31:0] r;

        // Reset state
        repeat (2) @(posedge clock5);
        #1;
        check("rst_rf_we", rf_we, 0);
        check("rst_rf_addr", rf_addr, 0);
        check("rst_rf_data", rf_data, 0);
        check("rst_aux_ready", aux_ready, 1);
        check("rst_pipe_stall", pipe_stall, 0);
        check("rst_pending_mask", pending_mask, 0);
        reset5 = 1'b1;
        cmp_en = 1;
        idle(2);

        // Idle drain: queued r7 appears in the mask, then is written next cycle
        cyc(0, 0, 0, 1, 5'd7, 32'h11);
        check("drain_mask", pending_mask, 32'h0000_0080);
        check("drain_we_early", rf_we, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("drain_we", rf_we, 1);
        check("drain_addr", rf_addr, 7);
        check("drain_data", rf_data, 32'h11);
        check("drain_mask_clr", pending_mask, 0);

        // Priority: writeback r3 wins, queued r9 takes the next idle slot
        cyc(1, 5'd3, 32'hAA, 1, 5'd9, 32'h55);
        check("prio_addr1", rf_addr, 3);
        check("prio_data1", rf_data, 32'hAA);
        check("prio_mask", pending_mask, 32'h0000_0200);
        cyc(0, 0, 0, 0, 0, 0);
        check("prio_addr2", rf_addr, 9);
        check("prio_data2", rf_data, 32'h55);
        idle(2);

        // Starvation: continuous writeback, one aux entry gets a stolen slot
        cyc(1, 5'd10, 32'h100, 1, 5'd5, 32'h1);
        idx = 1;
        stall_seen = 0;
        stall_at = -1;
        for (int k = 1; k <= 12; k++) begin
            bit stalled;
            stalled = pipe_stall;
            if (stalled) begin
                stall_seen++;
                stall_at = k;
            end
            cyc(1, 5'(10 + idx), 32'h100 + idx, 0, 0, 0);
            if (k == 9) begin
                check("starve_steal_addr", rf_addr, 5);
                check("starve_steal_data", rf_data, 32'h1);
            end
            if (k == 10) begin
                check("starve_replay_addr", rf_addr, 19);
                check("starve_replay_data", rf_data, 32'h109);
            end
            if (!stalled) idx++;
        end
        check("starve_stall_count", stall_seen, 1);
        check("starve_stall_cycle", stall_at, 9);
        idle(2);

        // Full / r0: r0 push handshakes but is dropped; ready falls after 4th push
        cyc(1, 5'd2, 32'h200, 1, 5'd0, 32'hDEAD);
        check("r0_mask", pending_mask, 0);
        check("r0_ready", aux_ready, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 5'd2, 32'h201 + i, 1, 5'(20 + i), 32'h300 + i);
            check("full_ready", aux_ready, (i < 3) ? 1 : 0);
        end
        cyc(1, 5'd2, 32'h210, 1, 5'd24, 32'h399);
        check("full_reject_mask", pending_mask, 32'h00F0_0000);
        check("full_reject_ready", aux_ready, 0);
        idle(8);

        // Push+pop around full with pointer wrap: aux writes retire in order
        for (int i = 0; i < 4; i++) begin
            cyc(1, 5'd2, 32'h400 + i, 1, 5'(12 + i), 32'h600 + i);
            exp_list.push_back('{addr: 5'(12 + i), data: 32'h600 + i});
        end
        rec_en = 1;
        for (int j = 0; j < 10; j++) begin
            if (mq.size() < DEPTH)
                exp_list.push_back('{addr: 5'(1 + j), data: 32'h700 + j});
            cyc(0, 0, 0, 1, 5'(1 + j), 32'h700 + j);
        end
        idle(8);
        rec_en = 0;
        check("wrap_count", obs.size(), exp_list.size());
        for (int i = 0; i < exp_list.size() && i < obs.size(); i++) begin
            check("wrap_order_addr", obs[i].addr, exp_list[i].addr);
            check("wrap_order_data", obs[i].data, exp_list[i].data);
        end

        // Randomized traffic: mixed phases of light and heavy writeback load
        for (int n = 0; n < 2000; n++) begin
            int wb_pct;
            wb_pct = ((n / 250) % 2 == 0) ? 55 : 95;
            cyc($urandom_range(0, 99) < wb_pct, 5'($urandom), $urandom,
                $urandom_range(0, 99) < 45, 5'($urandom), $urandom);
        end
        idle(12);

        // Mid-stream asynchronous reset with three entries queued
        for (int i = 0; i < 3; i++) begin
            cyc(1, 5'd2, 32'h800 + i, 1, 5'(4 + 2 * i), 32'h900 + i);
        end
        check("mrst_mask_before", pending_mask, 32'h0000_0150);
        check("mrst_we_before", rf_we, 1);
        #2;
        reset5 = 1'b0;
        #1;
        check("mrst_rf_we", rf_we, 0);
        check("mrst_aux_ready", aux_ready, 1);
        check("mrst_mask", pending_mask, 0);
        check("mrst_pipe_stall", pipe_stall, 0);
        @(posedge clock5);
        #1;
        wb_en = 0; aux_valid = 0;
        reset5 = 1'b1;
        idle(4);
        r = pending_mask;
        check("mrst_entries_gone", r, 0);

        cmp_en = 0;
        @(negedge clock5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
